// File: rtl/serial_full_subtractor.sv
// rtl/serial_full_subtractor.sv - bit-serial a - b - bin, LSB first, one bit per clock
module serial_full_subtractor #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             bin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] d,
    output logic             bout,
    output logic             ovf
);

    localparam int CW = (WIDTH <= 2) ? 1 : $clog2(WIDTH);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t           state;
    logic [WIDTH-1:0] a_reg;
    logic [WIDTH-1:0] b_reg;
    logic [WIDTH-1:0] res_reg;
    logic [CW-1:0]    cnt;
    logic             br;
    logic             a_msb;
    logic             b_msb;

    logic             x;
    logic             y;
    logic             diff_bit;
    logic             next_borrow;
    logic [WIDTH-1:0] res_next;
    logic             last_bit;

    // The single full-subtractor cell
    assign x           = a_reg[0];
    assign y           = b_reg[0];
    assign diff_bit    = x ^ y ^ br;
    assign next_borrow = (~x & y) | (~(x ^ y) & br);
    assign res_next    = {diff_bit, res_reg[WIDTH-1:1]};
    assign last_bit    = (cnt == CW'(WIDTH - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            a_reg   <= '0;
            b_reg   <= '0;
            res_reg <= '0;
            cnt     <= '0;
            br      <= 1'b0;
            a_msb   <= 1'b0;
            b_msb   <= 1'b0;
            busy    <= 1'b0;
            done    <= 1'b0;
            d       <= '0;
            bout    <= 1'b0;
            ovf     <= 1'b0;
        end else begin
            case (state)
                IDLE, DONE: begin
                    if (start) begin
                        state <= SHIFT;
                        a_reg <= a;
                        b_reg <= b;
                        br    <= bin;
                        a_msb <= a[WIDTH-1];
                        b_msb <= b[WIDTH-1];
                        cnt   <= '0;
                        busy  <= 1'b1;
                        done  <= 1'b0;
                    end else begin
                        state <= IDLE;
                        busy  <= 1'b0;
                        done  <= 1'b0;
                    end
                end
                SHIFT: begin
                    a_reg   <= a_reg >> 1;
                    b_reg   <= b_reg >> 1;
                    res_reg <= res_next;
                    br      <= next_borrow;
                    if (last_bit) begin
                        // Final bit goes straight into d; res_reg would lag by one edge
                        state <= DONE;
                        cnt   <= '0;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                        d     <= res_next;
                        bout  <= next_borrow;
                        ovf   <= (a_msb != b_msb) & (diff_bit != a_msb);
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                    done  <= 1'b0;
                end
            endcase
        end
    end

endmodule
